// File: rtl/dma_reg_arbiter.sv
// -----------------------------------------------------------------------------
// dma_reg_arbiter
//   Shares the single DMA register-block port between NUM_REQ requesters.
//   Picks a winner (round-robin or fixed priority), keeps exactly one access in
//   flight, issues a one-cycle registered strobe to the register block, waits
//   RD_LAT cycles for read data when needed and returns a one-cycle response to
//   the winner. Also produces the register block's registered active-low reset.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_we         per-requester request and direction (1 = write)
//   req_addr/req_wdata       packed per-requester address / write data
//   req_ready                one-hot grant, combinational, IDLE cycle only
//   rsp_valid/rsp_rdata      one-hot completion pulse and read data (0 on write)
//   busy                     high whenever an access is in flight
//   wr_en/rd_en/addr/wdata   registered register-block access port
//   rdata                    register-block read data
//   reg_rst_n                registered ~rst for the register block
// -----------------------------------------------------------------------------
module dma_reg_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy,
  output logic                      wr_en,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         addr,
  output logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W-1:0]         rdata,
  output logic                      reg_rst_n
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 3;
  // WAIT is entered with RD_LAT-1 remaining; the last WAIT edge captures rdata.
  localparam logic [CNT_W-1:0] WAIT_INIT = (RD_LAT > 0) ? CNT_W'(RD_LAT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic               we_q, we_d;
  logic               wr_en_q, wr_en_d;
  logic               rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               reg_rst_n_q;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;

  // Index of the k-th candidate in scan order.
  function automatic logic [IDX_W-1:0] scan_index(input logic [IDX_W-1:0] base, input int k);
    int idx;
    if (ARB_MODE == 1) idx = k;
    else               idx = (int'(base) + k) % NUM_REQ;
    return IDX_W'(idx);
  endfunction

  // Winner: first valid requester in scan order (from rr_ptr, or from 0 in fixed mode).
  // NOTE: every variable written in always_comb gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid[scan_index(rr_ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = scan_index(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = ~rst;
          gnt_d   = win_idx;
          we_d    = req_we[win_idx];
          wr_en_d = req_we[win_idx];
          rd_en_d = ~req_we[win_idx];
          addr_d  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[int'(win_idx)*DATA_W +: DATA_W];
          rdata_d = '0;  // writes report zero data
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_RESP;
        end else if (RD_LAT == 0) begin
          rdata_d = rdata;  // zero-latency block: data valid alongside rd_en
          state_d = S_RESP;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        rsp_rdata        = rdata_q;
        rr_ptr_d         = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    reg_rst_n_q <= ~rst;
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      we_q     <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign reg_rst_n = reg_rst_n_q;

endmodule
